// File: rtl/rca_adder.sv
// N-bit ripple-carry adder with the sum, carry-out and signed overflow registered one cycle after in_valid.
// Latency 1 cycle, one operation per cycle, no backpressure: the result is valid only in the out_valid cycle.

module rca_fa (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  logic w_p;

  assign w_p = i_a ^ i_b;
  assign o_s = w_p ^ i_c;
  assign o_c = (i_a & i_b) | (i_c & w_p);
endmodule

module rca_adder #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic [N-1:0] S,
  output logic         Cout,
  output logic         ovf,
  output logic         out_valid
);
  logic [N:0]   w_c;
  logic [N-1:0] w_s;
  logic         w_ovf;

  logic [N-1:0] r_s;
  logic         r_cout;
  logic         r_ovf;
  logic         r_vld;

  assign w_c[0] = Cin;

  for (genvar i = 0; i < N; i++) begin : g_fa
    rca_fa u_fa (
      .i_a (A[i]),
      .i_b (B[i]),
      .i_c (w_c[i]),
      .o_s (w_s[i]),
      .o_c (w_c[i+1])
    );
  end

  // For N=1, w_c[N-1] is Cin itself, so the same expression covers every width.
  assign w_ovf = w_c[N] ^ w_c[N-1];

  // Result registers only load when in_valid, so garbage on idle inputs never reaches the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s    <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
      r_vld  <= 1'b0;
    end else begin
      r_vld <= in_valid;
      if (in_valid) begin
        r_s    <= w_s;
        r_cout <= w_c[N];
        r_ovf  <= w_ovf;
      end
    end
  end

  assign S         = r_s;
  assign Cout      = r_cout;
  assign ovf       = r_ovf;
  assign out_valid = r_vld;
endmodule

// File: tb/tb_rca_adder.sv
// Directed and swept checks of rca_adder at N=4, N=1 and N=16.
`timescale 1ns/1ps
module tb_rca_adder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic in_valid;

  logic [3:0]  a4, b4, s4;
  logic        cin4, cout4, ovf4, vld4;
  logic [0:0]  a1, b1, s1;
  logic        cin1, cout1, ovf1, vld1;
  logic [15:0] a16, b16, s16;
  logic        cin16, cout16, ovf16, vld16;

  int n_checks = 0;
  int n_fail   = 0;

  rca_adder #(.N(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(a4), .B(b4), .Cin(cin4),
    .S(s4), .Cout(cout4), .ovf(ovf4), .out_valid(vld4)
  );

  rca_adder #(.N(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(a1), .B(b1), .Cin(cin1),
    .S(s1), .Cout(cout1), .ovf(ovf1), .out_valid(vld1)
  );

  rca_adder #(.N(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(a16), .B(b16), .Cin(cin16),
    .S(s16), .Cout(cout16), .ovf(ovf16), .out_valid(vld16)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Packed view {out_valid, Cout, ovf, S} for the N=4 instance.
  function automatic logic [31:0] obs4();
    return {25'd0, vld4, cout4, ovf4, s4};
  endfunction

  function automatic logic [31:0] exp4(input logic v, input logic co, input logic ov, input logic [3:0] s);
    return {25'd0, v, co, ov, s};
  endfunction

  task automatic drive4(input logic [3:0] a, input logic [3:0] b, input logic c);
    @(negedge clk);
    a4 = a; b4 = b; cin4 = c; in_valid = 1'b1;
  endtask

  task automatic one_shot4(input string tag, input logic [3:0] a, input logic [3:0] b, input logic c,
                           input logic co, input logic ov, input logic [3:0] s);
    drive4(a, b, c);
    @(negedge clk);
    in_valid = 1'b0;
    check(tag, obs4(), exp4(1'b1, co, ov, s));
  endtask

  logic [3:0] va [3];
  logic [3:0] vb [3];
  logic       vc [3];
  logic [3:0] vs [3];
  logic       vco[3];
  logic       vov[3];

  initial begin
    rst_n = 1'b0; in_valid = 1'b0;
    a4 = '0; b4 = '0; cin4 = 1'b0;
    a1 = '0; b1 = '0; cin1 = 1'b0;
    a16 = '0; b16 = '0; cin16 = 1'b0;

    #1;
    check("reset4", obs4(), 32'd0);
    check("reset16", {13'd0, vld16, cout16, ovf16, s16}, 32'd0);
    check("reset1", {28'd0, vld1, cout1, ovf1, s1}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    one_shot4("t1_sum", 4'b0001, 4'b0010, 1'b0, 1'b0, 1'b0, 4'b0011);
    @(negedge clk);
    check("t1_pulse", obs4(), exp4(1'b0, 1'b0, 1'b0, 4'b0011));
    one_shot4("t2_ovf", 4'b0111, 4'b0110, 1'b1, 1'b0, 1'b1, 4'b1110);
    one_shot4("t3_wrap", 4'b1111, 4'b1111, 1'b0, 1'b1, 1'b0, 4'b1110);
    one_shot4("t4_ripple", 4'b1111, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000);

    va = '{4'b0001, 4'b0111, 4'b1111};
    vb = '{4'b0010, 4'b0110, 4'b1111};
    vc = '{1'b0, 1'b1, 1'b0};
    vs = '{4'b0011, 4'b1110, 4'b1110};
    vco = '{1'b0, 1'b0, 1'b1};
    vov = '{1'b0, 1'b1, 1'b0};
    drive4(va[0], vb[0], vc[0]);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check($sformatf("b2b_%0d", i-1), obs4(), exp4(1'b1, vco[i-1], vov[i-1], vs[i-1]));
      if (i < 3) begin
        a4 = va[i]; b4 = vb[i]; cin4 = vc[i];
      end else begin
        in_valid = 1'b0;
        a4 = 4'bxxxx; b4 = 4'bxxxx; cin4 = 1'bx;
      end
    end
    @(negedge clk);
    check("b2b_idle", obs4(), exp4(1'b0, 1'b1, 1'b0, 4'b1110));
    @(negedge clk);
    check("x_hold", obs4(), exp4(1'b0, 1'b1, 1'b0, 4'b1110));

    drive4(4'b0101, 4'b0101, 1'b0);
    #2 rst_n = 1'b0;
    #1 check("rst_async", obs4(), 32'd0);
    @(negedge clk);
    check("rst_held", obs4(), 32'd0);
    rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    check("rst_no_stale", obs4(), 32'd0);

    // Exhaustive N=4 sweep, with random N=1 and N=16 operands alongside.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          int sum, sa, sb, ss, sum16, sa16, sb16, ss16, sum1, ss1;
          logic ov;
          @(negedge clk);
          in_valid = 1'b1;
          a4 = 4'(a); b4 = 4'(b); cin4 = 1'(c);
          a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
          a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
          if (a == 0 && b == 0) begin
            a16 = (c == 0) ? 16'hFFFF : 16'h7FFF;
            b16 = 16'h0001; cin16 = 1'b0;
          end
          @(posedge clk);
          #1;
          sum = a + b + c;
          sa = (a >= 8) ? a - 16 : a;
          sb = (b >= 8) ? b - 16 : b;
          ss = sa + sb + c;
          ov = (ss > 7) || (ss < -8);
          check("sweep4", obs4(), exp4(1'b1, sum[4], ov, sum[3:0]));

          sum16 = int'(a16) + int'(b16) + int'(cin16);
          sa16 = a16[15] ? int'(a16) - 65536 : int'(a16);
          sb16 = b16[15] ? int'(b16) - 65536 : int'(b16);
          ss16 = sa16 + sb16 + int'(cin16);
          ov = (ss16 > 32767) || (ss16 < -32768);
          check("sweep16", {13'd0, vld16, cout16, ovf16, s16}, {13'd0, 1'b1, sum16[16], ov, sum16[15:0]});

          sum1 = int'(a1) + int'(b1) + int'(cin1);
          ss1 = -int'(a1) - int'(b1) + int'(cin1);
          ov = (ss1 > 0) || (ss1 < -1);
          check("sweep1", {28'd0, vld1, cout1, ovf1, s1}, {28'd0, 1'b1, sum1[1], ov, sum1[0]});
        end
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("final_idle", {31'd0, vld4}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/rca_adder.md
Name: rca_adder

Overview:
- Parameterised N-bit ripple-carry adder built from a chain of N single-bit full adders, carry rippling LSB to MSB.
- Operands are sampled on an input-valid strobe; the sum, carry-out and signed-overflow flag are registered and presented one clock later with an output-valid strobe.
- Used as a generic arithmetic leaf wherever a small, area-cheap adder with registered outputs is needed.

Parameters:
- N, 4, operand and sum width in bits; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands valid this cycle; sampled on the rising edge of clk
- A  input  N  operand A (unsigned, or two's complement for ovf)
- B  input  N  operand B
- Cin  input  1  carry into bit 0
- S  output  N  registered sum bits
- Cout  output  1  registered carry out of bit N-1
- ovf  output  1  registered signed overflow (carry into MSB XOR carry out of MSB)
- out_valid  output  1  S/Cout/ovf hold a new result this cycle

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset: while rst_n=0, S=0, Cout=0, ovf=0 and out_valid=0 immediately, independent of clk. Deassertion is taken synchronously; the first capture happens on the first rising edge after rst_n=1.
- Datapath (combinational): c[0]=Cin. For i=0..N-1: s[i]=A[i]^B[i]^c[i] and c[i+1]=(A[i]&B[i])|(c[i]&(A[i]^B[i])). Implement as an explicit generate chain of full-adder cells, not a single "+" operator.
- Result: {Cout,S} equals A+B+Cin, exact in N+1 bits. ovf=c[N]^c[N-1]; for N=1, ovf=c[1]^Cin.
- Latency: exactly 1 cycle. If in_valid=1 at rising edge k, then S, Cout, ovf and out_valid=1 are visible after edge k.
- If in_valid=0 at an edge, out_valid=0 after that edge and S/Cout/ovf hold their previous values.
- Throughput: one operation per cycle. Back-to-back in_valid produces back-to-back results with no bubbles.
- No backpressure. The result must be consumed in the cycle out_valid is high.
- Wrap-around: the sum is modulo 2^N and the overflow carry appears only on Cout. All-ones + all-ones + 0 gives S=all-ones-minus-one and Cout=1.
- Reset asserted mid-operation drops the pending result. No out_valid is produced for operands sampled at or before the reset.
- X or Z on inputs while in_valid=0 must not corrupt the held outputs.

Test Plan:
- N=4, A=0001, B=0010, Cin=0, in_valid pulse -> next cycle S=0011, Cout=0, ovf=0, out_valid=1 for one cycle.
- N=4, A=0111, B=0110, Cin=1 -> S=1110, Cout=0, ovf=1 (signed 7+6+1 overflows).
- N=4, A=1111, B=1111, Cin=0 -> S=1110, Cout=1, ovf=0; then A=1111, B=0000, Cin=1 -> S=0000, Cout=1 (full carry ripple).
- Back-to-back: in_valid=1 for 3 cycles with the three vectors above -> three consecutive out_valid cycles with results in order. Then in_valid=0 -> out_valid=0 and S held at 1110.
- Reset: drive in_valid=1 with A=0101, B=0101, then assert rst_n=0 between clock edges -> S=0000, Cout=0, ovf=0, out_valid=0 immediately and no stale result after release.
- Exhaustive sweep at N=4: all A, B, Cin (512 cases) checked against {Cout,S}=A+B+Cin and the signed-overflow model. Repeat a random sweep at N=1 and N=16.
